// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage -- RV32I instruction decode stage with a single-entry output register.
//
// Accepts one instruction per cycle from fetch through a valid/ready handshake,
// decodes the register indices, immediate, write enable and illegal flag, and
// presents the decoded bundle to execute one cycle later. A held bundle stays
// put while execute stalls; a flush discards both the held and the incoming
// instruction.
//
// Parameters
//   CHECK_ILLEGAL  1 = full RV32I encoding check, 0 = opcode-only check
//
// Ports
//   clk            rising-edge clock
//   reset_n        synchronous, active-low reset
//   if_valid_i     fetch presents a valid instruction
//   if_instr_i     fetched instruction word
//   if_pc_i        PC of the fetched instruction
//   id_ready_o     decode can accept an instruction this cycle
//   ex_ready_i     execute consumes the decoded bundle this cycle
//   flush_i        redirect: drop held and incoming instruction
//   id_valid_o     decoded bundle valid
//   id_pc_o        PC of held instruction
//   id_instr_o     raw word of held instruction
//   id_rs1_o       instr[19:15]
//   id_rs2_o       instr[24:20]
//   id_rd_o        instr[11:7]
//   id_opcode_o    instr[6:0]
//   id_funct3_o    instr[14:12]
//   id_funct7b5_o  instr[30]
//   id_imm_o       sign-extended immediate
//   id_rd_we_o     register-file write enable
//   id_illegal_o   illegal-instruction flag
// -----------------------------------------------------------------------------
module id_stage #(
  parameter int unsigned CHECK_ILLEGAL = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_valid_i,
  input  logic [31:0] if_instr_i,
  input  logic [31:0] if_pc_i,
  output logic        id_ready_o,
  input  logic        ex_ready_i,
  input  logic        flush_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o,
  output logic [4:0]  id_rs1_o,
  output logic [4:0]  id_rs2_o,
  output logic [4:0]  id_rd_o,
  output logic [6:0]  id_opcode_o,
  output logic [2:0]  id_funct3_o,
  output logic        id_funct7b5_o,
  output logic [31:0] id_imm_o,
  output logic        id_rd_we_o,
  output logic        id_illegal_o
);

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic FULL_CHECK = (CHECK_ILLEGAL != 0);

  // Immediate selected purely by opcode; unknown opcodes yield zero.
  function automatic logic [31:0] imm_gen(input logic [31:0] i);
    logic [31:0] r;
    case (i[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM:
        r = {{20{i[31]}}, i[31:20]};
      OPC_STORE:
        r = {{20{i[31]}}, i[31:25], i[11:7]};
      OPC_BRANCH:
        r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        r = {i[31:12], 12'h000};
      OPC_JAL:
        r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:
        r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Illegal-instruction detection. The opcode check always applies; the
  // funct3/funct7 checks only when full checking is enabled.
  function automatic logic illegal_gen(input logic [31:0] i, input logic full);
    logic       known;
    logic       bad;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = i[14:12];
    f7 = i[31:25];
    case (i[6:0])
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC,
      OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_MISC_MEM, OPC_SYSTEM:
        known = 1'b1;
      default:
        known = 1'b0;
    endcase
    if (i[1:0] != 2'b11) begin
      known = 1'b0;
    end else begin
      known = known;
    end
    bad = 1'b0;
    if (full) begin
      case (i[6:0])
        OPC_LOAD:   bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        OPC_STORE:  bad = (f3 > 3'd2);
        OPC_BRANCH: bad = (f3 == 3'd2) || (f3 == 3'd3);
        OPC_JALR:   bad = (f3 != 3'd0);
        OPC_OP_IMM: begin
          if (f3 == 3'd1) begin
            bad = (f7 != 7'h00);
          end else if (f3 == 3'd5) begin
            bad = (f7 != 7'h00) && (f7 != 7'h20);
          end else begin
            bad = 1'b0;
          end
        end
        OPC_OP: begin
          if (f7 == 7'h00) begin
            bad = 1'b0;
          end else if (f7 == 7'h20) begin
            // Only SUB and SRA use the alternate funct7.
            bad = (f3 != 3'd0) && (f3 != 3'd5);
          end else begin
            bad = 1'b1;
          end
        end
        // Only ECALL and EBREAK are supported system instructions.
        OPC_SYSTEM: bad = (i != 32'h0000_0073) && (i != 32'h0010_0073);
        default:    bad = 1'b0;
      endcase
    end else begin
      bad = 1'b0;
    end
    return !known || bad;
  endfunction

  // Write enable for instructions that produce a register result to rd != x0.
  function automatic logic rd_we_gen(input logic [31:0] i, input logic illegal);
    logic writes;
    case (i[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR:
        writes = 1'b1;
      default:
        writes = 1'b0;
    endcase
    return writes && !illegal && (i[11:7] != 5'd0);
  endfunction

  logic        valid_q,   valid_d;
  logic [31:0] pc_q,      pc_d;
  logic [31:0] instr_q,   instr_d;
  logic [31:0] imm_q,     imm_d;
  logic        rd_we_q,   rd_we_d;
  logic        illegal_q, illegal_d;
  logic        illegal_s;

  assign id_ready_o = !valid_q || ex_ready_i;
  assign illegal_s  = illegal_gen(if_instr_i, FULL_CHECK);

  // Next-state for the output register: flush > capture/consume > stall hold.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    imm_d     = imm_q;
    rd_we_d   = rd_we_q;
    illegal_d = illegal_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (id_ready_o) begin
      if (if_valid_i) begin
        valid_d   = 1'b1;
        pc_d      = if_pc_i;
        instr_d   = if_instr_i;
        imm_d     = imm_gen(if_instr_i);
        rd_we_d   = rd_we_gen(if_instr_i, illegal_s);
        illegal_d = illegal_s;
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Output register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      pc_q      <= 32'h0000_0000;
      instr_q   <= 32'h0000_0000;
      imm_q     <= 32'h0000_0000;
      rd_we_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      imm_q     <= imm_d;
      rd_we_q   <= rd_we_d;
      illegal_q <= illegal_d;
    end
  end

  // Raw fields are slices of the registered word, so they share its timing.
  assign id_valid_o    = valid_q;
  assign id_pc_o       = pc_q;
  assign id_instr_o    = instr_q;
  assign id_rs1_o      = instr_q[19:15];
  assign id_rs2_o      = instr_q[24:20];
  assign id_rd_o       = instr_q[11:7];
  assign id_opcode_o   = instr_q[6:0];
  assign id_funct3_o   = instr_q[14:12];
  assign id_funct7b5_o = instr_q[30];
  assign id_imm_o      = imm_q;
  assign id_rd_we_o    = rd_we_q;
  assign id_illegal_o  = illegal_q;

endmodule
